// File: rtl/aes_seq_pkg.sv
// Shared types for the AES-to-UART sequencer: FSM states, line terminators, hex encoder.
// Optional CR/LF trailer is enabled with `define AES_SEQ_CRLF_EN.
package aes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, CAPTURE, SEND, TERM, FINISH
  } seq_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Lowercase hex: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/aes_seq_serializer.sv
// Holds the captured cyphertext and streams it as hex characters (and, when
// AES_SEQ_CRLF_EN is defined, a CR/LF trailer) over a valid/ready handshake.
module aes_seq_serializer
  import aes_seq_pkg::*;
#(
  parameter int CYPHER_SIZE = 128,
  parameter int NIBBLES     = CYPHER_SIZE / 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [CYPHER_SIZE-1:0] cypher_i,
  input  logic                   hex_en_i,
  input  logic                   crlf_en_i,
  input  logic                   tx_ready_i,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  output logic                   last_sent_o
);

  localparam int IDX_W = $clog2(NIBBLES);

  logic [CYPHER_SIZE-1:0] cypher_q;
  logic [CYPHER_SIZE-1:0] shifted;
  logic [IDX_W-1:0]       nib_idx_q, nib_idx_d;
  logic                   xfer;

  // Current nibble is always brought to the top of the word
  assign shifted     = cypher_q << {nib_idx_q, 2'b00};
  assign tx_valid_o  = hex_en_i | crlf_en_i;
  assign xfer        = tx_valid_o & tx_ready_i;
  assign last_sent_o = xfer & (hex_en_i ? (nib_idx_q == IDX_W'(NIBBLES - 1)) : nib_idx_q[0]);

  always_comb begin
    tx_data_o = 8'h00;
    if (hex_en_i)       tx_data_o = nib2ascii(shifted[CYPHER_SIZE-1 -: 4]);
    else if (crlf_en_i) tx_data_o = nib_idx_q[0] ? ASCII_LF : ASCII_CR;
  end

  // Index clears on the last hex byte so the trailer can reuse bit 0 as CR/LF select
  always_comb begin
    nib_idx_d = nib_idx_q;
    if (load_i)    nib_idx_d = '0;
    else if (xfer) nib_idx_d = last_sent_o ? '0 : nib_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cypher_q  <= '0;
      nib_idx_q <= '0;
    end else begin
      nib_idx_q <= nib_idx_d;
      if (load_i) cypher_q <= cypher_i;
    end
  end

endmodule

// File: rtl/aes_uart_sequencer.sv
// One AES-128 encryption per start request, result streamed out as 32 lowercase
// hex characters; define AES_SEQ_CRLF_EN to append CR/LF (34 bytes per block).
module aes_uart_sequencer
  import aes_seq_pkg::*;
#(
  parameter int CYPHER_SIZE = 128,
  parameter int AES_LATENCY = 11,
  parameter int LAT_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYPHER_SIZE-1:0] plaintext,
  input  logic [CYPHER_SIZE-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   aes_rst,
  output logic                   aes_ena,
  output logic [CYPHER_SIZE-1:0] aes_data_in,
  output logic [CYPHER_SIZE-1:0] aes_key,
  input  logic [CYPHER_SIZE-1:0] aes_cypher_out,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data
);

  localparam int NIBBLES = CYPHER_SIZE / 4;

  seq_state_e             state_q, state_d;
  logic [LAT_BITS-1:0]    lat_q, lat_d;
  logic [CYPHER_SIZE-1:0] pt_q, key_q;
  logic                   hex_en, crlf_en, last_sent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      pt_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (state_q == IDLE && start) begin
        pt_q  <= plaintext;
        key_q <= key;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = (state_q == RUN) ? lat_q + LAT_BITS'(1) : '0;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (lat_q == LAT_BITS'(AES_LATENCY - 1)) state_d = CAPTURE;
      CAPTURE: state_d = SEND;
`ifdef AES_SEQ_CRLF_EN
      SEND:    if (last_sent) state_d = TERM;
      TERM:    if (last_sent) state_d = FINISH;
`else
      SEND:    if (last_sent) state_d = FINISH;
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == FINISH);
    aes_rst = (state_q == IDLE) || (state_q == LOAD);
    aes_ena = (state_q == RUN);
    hex_en  = (state_q == SEND);
`ifdef AES_SEQ_CRLF_EN
    crlf_en = (state_q == TERM);
`else
    crlf_en = 1'b0;
`endif
  end

  assign aes_data_in = pt_q;
  assign aes_key     = key_q;

  aes_seq_serializer #(
    .CYPHER_SIZE(CYPHER_SIZE),
    .NIBBLES    (NIBBLES)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == CAPTURE),
    .cypher_i   (aes_cypher_out),
    .hex_en_i   (hex_en),
    .crlf_en_i  (crlf_en),
    .tx_ready_i (tx_ready),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .last_sent_o(last_sent)
  );

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Scoreboard bench for aes_uart_sequencer with a latency-accurate stand-in for the AES core.
// Compile with AES_SEQ_CRLF_EN defined to expect the CR/LF trailer.
module tb_aes_uart_sequencer;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 0, reset = 1, start = 0, tx_ready = 1;
  logic [127:0] plaintext = '0, key = '0;
  logic         busy, done, aes_rst, aes_ena, tx_valid;
  logic [127:0] aes_data_in, aes_key, aes_cypher_out;
  logic [7:0]   tx_data;

  int checks = 0, errors = 0;
  int xfer_cnt = 0, ena_cnt = 0;
  logic [7:0] exp_q[$];
  string fips_str = "69c4e0d86a7b0430d8cdb78070b4c55a";

  aes_uart_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .plaintext(plaintext), .key(key),
    .busy(busy), .done(done), .aes_rst(aes_rst), .aes_ena(aes_ena),
    .aes_data_in(aes_data_in), .aes_key(aes_key), .aes_cypher_out(aes_cypher_out),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  // Core stand-in: result valid only after exactly 11 enabled cycles since aes_rst
  int mcnt = 0;
  always @(posedge clk) begin
    if (aes_rst) mcnt <= 0;
    else if (aes_ena) mcnt <= mcnt + 1;
  end
  assign aes_cypher_out = (mcnt == 11) ?
    ((aes_data_in == PT && aes_key == KEY) ? CT : (aes_data_in ^ aes_key)) :
    {4{32'hdeadbeef}};

  always @(negedge clk) if (!reset && aes_ena) ena_cnt++;

  // Scoreboard monitor: byte order, stall stability, done timing
  bit         prev_stall = 0, last_xfer_d = 0;
  logic [7:0] prev_data = 0, e;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 0;
      last_xfer_d = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h, required valid=1 data=%h", tx_valid, tx_data, prev_data);
        end
      end
      if (done || last_xfer_d) begin
        checks++;
        if (done !== last_xfer_d) begin
          errors++;
          $display("FAIL done_timing: done=%b, required %b", done, last_xfer_d);
        end
      end
      last_xfer_d = 0;
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got byte %h with nothing expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, e);
          end
          last_xfer_d = (exp_q.size() == 0);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic push_trailer();
`ifdef AES_SEQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic push_fips();
    for (int i = 0; i < 32; i++) exp_q.push_back(fips_str[i]);
    push_trailer();
  endtask

  task automatic push_model(input logic [127:0] ct);
    logic [3:0] n;
    for (int i = 0; i < 32; i++) begin
      n = ct[127-4*i -: 4];
      exp_q.push_back(n < 10 ? 8'h30 + {4'h0, n} : 8'h61 + {4'h0, n} - 8'd10);
    end
    push_trailer();
  endtask

  // Leaves the caller at #1 after the edge that sampled start; scrambles inputs afterwards
  task automatic start_block(input logic [127:0] p, input logic [127:0] k);
    @(posedge clk); #1;
    plaintext = p; key = k; start = 1;
    @(posedge clk); #1;
    start = 0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_block(input bit bp, input int max);
    int  lowcnt = 0, r;
    bit  seen = 0;
    for (int c = 0; c < max && !seen; c++) begin
      @(posedge clk); #1;
      if (!bp) tx_ready = 1;
      else if (lowcnt > 0) begin tx_ready = 0; lowcnt--; end
      else begin
        r = $urandom_range(0, 19);
        if (r == 0) begin lowcnt = 19; tx_ready = 0; end
        else tx_ready = (r > 7);
      end
      @(negedge clk);
      if (done) seen = 1;
    end
    tx_ready = 1;
    checks++;
    if (!seen) begin errors++; $display("FAIL block_timeout: done not seen in %0d cycles", max); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL block_leftover: %0d bytes missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, aes_rst, aes_ena, tx_valid, tx_data} !== {5'b00100, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: busy/done/rst/ena/valid/data=%b%b%b%b%b/%h, required 00100/00",
               busy, done, aes_rst, aes_ena, tx_valid, tx_data);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || aes_rst !== 1) begin errors++; $display("FAIL idle_state: busy=%b aes_rst=%b, required 0 1", busy, aes_rst); end
  endtask

  task automatic test_fips();
    int n = 1;
    tx_ready = 1; ena_cnt = 0;
    push_fips();
    start_block(PT, KEY);
    while (n < 40) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (aes_rst !== 1 || aes_ena !== 0 || busy !== 1) begin
          errors++;
          $display("FAIL load_state: rst=%b ena=%b busy=%b, required 1 0 1", aes_rst, aes_ena, busy);
        end
      end
      if (tx_valid) break;
      @(posedge clk); n++;
    end
    checks++;
    if (n != 14) begin errors++; $display("FAIL first_valid_latency: %0d cycles, required 14", n); end
    wait_block(0, 200);
    checks++;
    if (ena_cnt != 11) begin errors++; $display("FAIL ena_cycles: %0d, required 11", ena_cnt); end
  endtask

  task automatic test_backpressure();
    ena_cnt = 0;
    push_fips();
    start_block(PT, KEY);
    wait_block(1, 3000);
    checks++;
    if (ena_cnt != 11) begin errors++; $display("FAIL ena_cycles_bp: %0d, required 11", ena_cnt); end
  endtask

  task automatic test_start_ignored();
    int bad = 0, extra = 0, c;
    tx_ready = 1; ena_cnt = 0;
    push_fips();
    start_block(PT, KEY);
    repeat (4) @(posedge clk); #1;
    plaintext = ~PT; key = ~KEY; start = 1;
    @(posedge clk); #1 start = 0;
    for (c = 0; c < 40 && !tx_valid; c++) @(posedge clk);
    #1 plaintext = ~PT; start = 1;
    @(posedge clk); #1 start = 0;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) bad++;
      if (done) break;
    end
    checks++;
    if (bad != 0 || done !== 1) begin errors++; $display("FAIL busy_hold: %0d idle cycles, done=%b, required 0 1", bad, done); end
    repeat (30) begin @(negedge clk); if (tx_valid || busy) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL start_queued: %0d active cycles after done, required 0", extra); end
    checks++;
    if (ena_cnt != 11) begin errors++; $display("FAIL ena_cycles_ign: %0d, required 11", ena_cnt); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ign_leftover: %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int c;
    tx_ready = 1; xfer_cnt = 0;
    push_fips();
    start_block(PT, KEY);
    for (c = 0; c < 200 && xfer_cnt < 10; c++) begin @(posedge clk); #2; end
    reset = 1;
    exp_q.delete();
    #1;
    checks++;
    if (tx_valid !== 0 || busy !== 0 || aes_rst !== 1 || c >= 200) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b rst=%b wait=%0d, required 0 0 1 <200", tx_valid, busy, aes_rst, c);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    ena_cnt = 0;
    push_fips();
    start_block(PT, KEY);
    wait_block(0, 200);
    checks++;
    if (ena_cnt != 11) begin errors++; $display("FAIL ena_cycles_rst: %0d, required 11", ena_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p2 = 128'h0123456789abcdeffedcba9876543210;
    push_model(p2);
    start_block(p2, '0);
    wait_block(1, 3000);
    push_fips();
    start_block(PT, KEY);
    wait_block(0, 200);
  endtask

  initial begin
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_uart_sequencer.md
Name: aes_uart_sequencer

Overview:
Controller that runs one AES-128 encryption per request and streams the result out over UART as ASCII hex. It latches plaintext and key, resets and enables the AES_Encrypt core, and counts a fixed core latency. It then captures cypher_out and hands 32 hex characters, MSB nibble first, to the UART transmitter one byte at a time over a valid/ready handshake. It replaces the free-running tock/aes_idx sequencing in the AES top level.

Parameters:
CYPHER_SIZE, 128, width of plaintext, key and cyphertext.
NIBBLES, CYPHER_SIZE/4 (32), hex characters per block.
AES_LATENCY, 11, clk cycles with aes_ena high before cypher_out is valid (Nr+1).
LAT_BITS, 5, latency counter width; must satisfy 2^LAT_BITS > AES_LATENCY.

Ports:
clk  in  1  sequencer and AES core clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
plaintext  in  CYPHER_SIZE  block to encrypt; latched on accepted start
key  in  CYPHER_SIZE  cypher key; latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last character handshakes
aes_rst  out  1  synchronous reset to the AES core
aes_ena  out  1  AES core enable
aes_data_in  out  CYPHER_SIZE  latched plaintext
aes_key  out  CYPHER_SIZE  latched key
aes_cypher_out  in  CYPHER_SIZE  AES core result
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter can accept a byte
tx_data  out  8  ASCII character

Behaviour:
- Reset values: state IDLE, busy 0, done 0, aes_rst 1, aes_ena 0, tx_valid 0, tx_data 0, latch registers 0, counters 0.
- IDLE: aes_rst=1. When start=1, latch plaintext/key, go to LOAD. start in any other state is ignored, with no queuing.
- LOAD: 1 cycle, aes_rst=1, aes_ena=0. Next state RUN with lat_cnt=0.
- RUN: aes_rst=0, aes_ena=1, lat_cnt increments each cycle. When lat_cnt==AES_LATENCY-1, go to CAPTURE.
- CAPTURE: 1 cycle, aes_ena=0. cypher register <= aes_cypher_out. nib_idx=0. Next state SEND.
- SEND: tx_valid=1. tx_data=ASCII of cypher[CYPHER_SIZE-1-4*nib_idx -: 4]. Digits 0-9 map to 0x30-0x39; a-f map to 0x61-0x66, lowercase.
  - A transfer occurs on a cycle where tx_valid&&tx_ready. On transfer, nib_idx increments.
  - On the transfer at nib_idx==NIBBLES-1, go to FINISH (or TERM, see Optional Feature).
  - tx_data and tx_valid stay stable until the transfer; tx_valid never drops without one.
- FINISH: done=1 for 1 cycle, tx_valid=0. Return to IDLE.
- Total latency from start to first tx_valid: 1+1+AES_LATENCY+1 = 14 cycles at default.
- Stalls: tx_ready held low stalls indefinitely in SEND, with no timeout.
- Async reset mid-operation: return to IDLE immediately. Drop tx_valid and discard the partial block; the next start begins a fresh block.
- nib_idx width is $clog2(NIBBLES). It never wraps inside SEND because the exit condition is checked first.
- The latched inputs are held constant from LOAD through FINISH, so input changes after start have no effect.

Optional Feature:
AES_SEQ_CRLF_EN:
- Defined: after the last hex character, state TERM sends 0x0D, then 0x0A, using the same handshake; done pulses after 0x0A transfers (34 bytes per block).
- Undefined: TERM does not exist and 32 bytes are sent per block.

Decomposition:
- Shared package aes_seq_pkg: state enum (IDLE, LOAD, RUN, CAPTURE, SEND, TERM, FINISH), ASCII_CR=8'h0D, ASCII_LF=8'h0A, and the nibble-to-ASCII function.
- One sub-module, aes_seq_serializer: holds the cypher register, nib_idx and the valid/ready logic, and reports last_sent to the FSM.

Test Plan:
1. FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tx_ready=1 -> 32 bytes spell "69c4e0d86a7b0430d8cdb78070b4c55a"; first tx_valid 14 cycles after start; done one cycle after byte 32.
2. Backpressure: tx_ready toggled randomly, including 20-cycle low periods -> identical byte sequence, tx_data stable while valid&&!ready, no lost or duplicate bytes.
3. start pulsed during RUN and during SEND -> ignored; exactly one block emitted, busy stays 1 until FINISH.
4. reset asserted mid-SEND at byte 10 -> tx_valid 0 and busy 0 immediately; a new start with the same vector emits all 32 bytes from '6'.
5. aes_rst/aes_ena timing: aes_rst high in IDLE/LOAD and aes_ena high for exactly 11 cycles per block.
6. With AES_SEQ_CRLF_EN: same vector -> 34 bytes ending 0x0D,0x0A; done after the 0x0A transfer.
